// File: rtl/counter_pkg.sv
// counter_pkg: shared FSM state encoding and direction constants for the up/down counter
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_next_calc.sv
// counter_next_calc: combinational step/wrap value and terminal detect for the modulus counter
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] limit,
    input  logic             up_down,
    output logic [WIDTH-1:0] next_count,
    output logic             at_terminal
);

    // up treats anything at or above limit as terminal so a count stranded by a lowered limit wraps
    always_comb begin
        at_terminal = (up_down == DIR_UP) ? (count >= limit) : (count == '0);
        next_count  = at_terminal ? ((up_down == DIR_UP) ? '0 : limit)
                                  : ((up_down == DIR_DOWN) ? count - 1'b1 : count + 1'b1);
    end

endmodule

// File: rtl/counter_updown_mod_async_reset.sv
// counter_updown_mod_async_reset: up/down modulus counter with load, one-shot FSM and tc pulse; optional COUNTER_OVF_STICKY_EN adds a sticky overflow flag
module counter_updown_mod_async_reset
    import counter_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter bit               NEGEDGE   = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock0,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] limit,
`ifdef COUNTER_OVF_STICKY_EN
    input  logic             ovf_clear,
    output logic             ovf_sticky,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    typedef struct packed {
        state_t           state;
        logic [WIDTH-1:0] count;
        logic             tc;
`ifdef COUNTER_OVF_STICKY_EN
        logic             ovf;
`endif
    } regs_t;

    regs_t            r;
    regs_t            n;
    logic [WIDTH-1:0] next_count;
    logic             at_terminal;

    counter_next_calc #(.WIDTH(WIDTH)) u_calc (
        .count      (r.count),
        .limit      (limit),
        .up_down    (up_down),
        .next_count (next_count),
        .at_terminal(at_terminal)
    );

    // next state: load wins, then IDLE/RUN stepping; DONE only leaves via load
    always_comb begin
        n    = r;
        n.tc = 1'b0;
        if (load) begin
            n.count = (load_value > limit) ? limit : load_value;
            n.state = ST_IDLE;
        end else if (enable && r.state != ST_DONE) begin
            n.tc    = at_terminal;
            n.state = (at_terminal && oneshot) ? ST_DONE : ST_RUN;
            n.count = (at_terminal && oneshot) ? r.count : next_count;
        end
`ifdef COUNTER_OVF_STICKY_EN
        n.ovf = n.tc | (r.ovf & ~ovf_clear);
`endif
    end

    generate
        if (NEGEDGE) begin : g_neg
            // state register on the falling edge, async reset
            always_ff @(negedge clock0 or posedge reset) begin
                if (reset) begin
                    r       <= '0;
                    r.count <= RESET_VAL;
                end else begin
                    r <= n;
                end
            end
        end else begin : g_pos
            // state register on the rising edge, async reset
            always_ff @(posedge clock0 or posedge reset) begin
                if (reset) begin
                    r       <= '0;
                    r.count <= RESET_VAL;
                end else begin
                    r <= n;
                end
            end
        end
    endgenerate

    assign count = r.count;
    assign tc    = r.tc;
    assign busy  = (r.state == ST_RUN);
`ifdef COUNTER_OVF_STICKY_EN
    assign ovf_sticky = r.ovf;
`endif

endmodule

// File: tb/tb_counter_updown_mod_async_reset.sv
// tb_counter_updown_mod_async_reset: table-driven scoreboard bench for the up/down modulus counter
module tb_counter_updown_mod_async_reset;

    typedef struct {
        bit          ld;
        logic [15:0] lv;
        bit          en;
        bit          ud;
        bit          os;
        logic [15:0] lim;
        logic [15:0] e_count;
        bit          e_tc;
        bit          e_busy;
    } vec_t;

    typedef struct {
        logic [15:0] count;
        bit          tc;
        bit          busy;
    } exp_t;

    logic        clock0 = 1'b0;
    logic        reset;
    logic        enable;
    logic        up_down;
    logic        oneshot;
    logic        load;
    logic [15:0] load_value;
    logic [15:0] limit;
    logic [15:0] count;
    logic        tc;
    logic        busy;
`ifdef COUNTER_OVF_STICKY_EN
    logic        ovf_clear;
    logic        ovf_sticky;
`endif

    int   n_vec  = 0;
    int   n_fail = 0;
    vec_t tbl[$];
    exp_t sb[$];

    counter_updown_mod_async_reset #(
        .WIDTH    (16),
        .NEGEDGE  (1'b1),
        .RESET_VAL(16'd0)
    ) dut (
        .clock0    (clock0),
        .reset     (reset),
        .enable    (enable),
        .up_down   (up_down),
        .oneshot   (oneshot),
        .load      (load),
        .load_value(load_value),
        .limit     (limit),
`ifdef COUNTER_OVF_STICKY_EN
        .ovf_clear (ovf_clear),
        .ovf_sticky(ovf_sticky),
`endif
        .count     (count),
        .tc        (tc),
        .busy      (busy)
    );

    always #5 clock0 = ~clock0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit ld, input logic [15:0] lv, input bit en, input bit ud,
                                input bit os, input logic [15:0] lim, input logic [15:0] ec,
                                input bit et, input bit eb);
        vec_t v;
        v.ld = ld; v.lv = lv; v.en = en; v.ud = ud; v.os = os; v.lim = lim;
        v.e_count = ec; v.e_tc = et; v.e_busy = eb;
        return v;
    endfunction

    // drive one vector, queue its expectation, then check after the falling edge has updated the DUT
    task automatic apply(input vec_t v, input string name);
        exp_t e;
        load = v.ld; load_value = v.lv; enable = v.en;
        up_down = v.ud; oneshot = v.os; limit = v.lim;
        sb.push_back('{v.e_count, v.e_tc, v.e_busy});
        @(posedge clock0);
        #1;
        e = sb.pop_front();
        chk({name, ".count"}, count, e.count);
        chk({name, ".tc"}, {15'd0, tc}, {15'd0, e.tc});
        chk({name, ".busy"}, {15'd0, busy}, {15'd0, e.busy});
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; up_down = 1'b1; oneshot = 1'b0;
        load = 1'b0; load_value = '0; limit = 16'd100;
`ifdef COUNTER_OVF_STICKY_EN
        ovf_clear = 1'b0;
`endif
        @(posedge clock0);
        #1;
        chk("reset.count", count, 16'd0);
        chk("reset.tc", {15'd0, tc}, 16'd0);
        chk("reset.busy", {15'd0, busy}, 16'd0);
        reset = 1'b0;

        enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            #2;
            chk("edge.pre_fall", count, 16'(i - 1));
            @(negedge clock0);
            #1;
            chk("edge.post_fall", count, 16'(i));
            @(posedge clock0);
            #1;
            chk("edge.post_rise", count, 16'(i));
        end
        chk("edge.busy", {15'd0, busy}, 16'd1);

        enable = 1'b0;
        reset  = 1'b1;
        #1;
        chk("areset.count", count, 16'd0);
        chk("areset.busy", {15'd0, busy}, 16'd0);
        #1;
        reset = 1'b0;

        // continuous up wrap, limit 5
        for (int i = 1; i <= 5; i++) tbl.push_back(mk(0, 0, 1, 1, 0, 5, 16'(i), 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 5, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 5, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 5, 1, 0, 1));
        // load clamp beats enable
        tbl.push_back(mk(1, 20, 1, 1, 0, 10, 10, 0, 0));
        // down one-shot from 3
        tbl.push_back(mk(1, 3, 0, 1, 0, 10, 3, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 10, 2, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 10, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 10, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 10, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 10, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 10, 0, 0, 0));
        tbl.push_back(mk(1, 4, 0, 1, 0, 10, 4, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 10, 4, 0, 0) );
        tbl.delete(tbl.size() - 1);
        // limit lowered below a running count
        tbl.push_back(mk(1, 8, 0, 1, 0, 10, 8, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 5, 0, 1, 1));
        // limit 0 continuous, then one-shot
        tbl.push_back(mk(1, 7, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0));
        // down continuous wrap to limit
        tbl.push_back(mk(1, 1, 0, 0, 0, 3, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 3, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 3, 3, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 3, 2, 0, 1));
        // up one-shot stops at limit
        tbl.push_back(mk(1, 2, 0, 1, 1, 3, 2, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 3, 3, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 1, 3, 3, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 3, 3, 0, 0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

`ifdef COUNTER_OVF_STICKY_EN
        ovf_clear = 1'b1;
        apply(mk(1, 0, 0, 1, 0, 1, 0, 0, 0), "ovf.clr0");
        chk("ovf.init", {15'd0, ovf_sticky}, 16'd0);
        ovf_clear = 1'b0;
        apply(mk(0, 0, 1, 1, 0, 1, 1, 0, 1), "ovf.s1");
        chk("ovf.s1", {15'd0, ovf_sticky}, 16'd0);
        apply(mk(0, 0, 1, 1, 0, 1, 0, 1, 1), "ovf.wrap1");
        chk("ovf.wrap1", {15'd0, ovf_sticky}, 16'd1);
        apply(mk(0, 0, 1, 1, 0, 1, 1, 0, 1), "ovf.s2");
        apply(mk(0, 0, 1, 1, 0, 1, 0, 1, 1), "ovf.wrap2");
        chk("ovf.wrap2", {15'd0, ovf_sticky}, 16'd1);
        apply(mk(0, 0, 1, 1, 0, 1, 1, 0, 1), "ovf.s3");
        ovf_clear = 1'b1;
        apply(mk(0, 0, 1, 1, 0, 1, 0, 1, 1), "ovf.set_wins");
        chk("ovf.set_wins", {15'd0, ovf_sticky}, 16'd1);
        apply(mk(0, 0, 1, 1, 0, 1, 1, 0, 1), "ovf.clear");
        chk("ovf.clear", {15'd0, ovf_sticky}, 16'd0);
        ovf_clear = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_updown_mod_async_reset.md
Name: counter_updown_mod_async_reset

Overview:
- Parametrised successor to the fixed 16-bit falling-edge up counter.
- Generalises width and active edge, and adds:
  - up/down direction
  - programmable modulus limit
  - synchronous load
  - continuous or one-shot mode with a small control FSM
  - registered terminal-count pulse
- Used as the general timer/counter primitive in the simple_registers family.

Parameters:
- WIDTH, 16, counter width in bits (>= 2).
- NEGEDGE, 1: 1 = all state updates on falling edge of clock0; 0 = rising edge.
- RESET_VAL, 0, count value on reset; must be <= 2^WIDTH-1.

Ports:
- clock0  input  1  single clock; active edge per NEGEDGE.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  count enable, sampled on active edge.
- up_down  input  1  1 = count up, 0 = count down.
- oneshot  input  1  1 = stop at terminal (DONE); 0 = wrap continuously.
- load  input  1  synchronous load strobe.
- load_value  input  WIDTH  value loaded when load=1.
- limit  input  WIDTH  modulus upper bound; count range is 0..limit.
- count  output  WIDTH  current count (registered).
- tc  output  1  one-cycle terminal-count pulse (registered).
- busy  output  1  high while FSM is in RUN.

Behaviour:
- Clock and reset:
  - One clock (clock0); reset is asynchronous and active-high.
  - reset=1 immediately forces count=RESET_VAL, tc=0, busy=0, state=IDLE, regardless of clock.
- FSM states: IDLE, RUN, DONE. busy = (state==RUN).
- Priority on each active edge: load > count activity.
- Load:
  - load=1 sets count = (load_value > limit) ? limit : load_value, state=IDLE, tc=0.
  - Load is valid in any state.
- IDLE:
  - enable=1 moves to RUN, and the first count step occurs on that same edge.
  - enable=0 holds count.
- RUN, enable=0: count held, state stays RUN, tc=0.
- RUN, enable=1, terminal check:
  - Terminal value T = limit when counting up, 0 when counting down.
  - Up mode uses count >= limit as terminal, so a count stranded above a reduced limit wraps to 0.
- RUN, enable=1, not at terminal: count ±1, tc=0.
- RUN, enable=1, at terminal, oneshot=0:
  - Wrap: up goes to 0, down goes to limit.
  - tc=1 for exactly one period after that edge.
- RUN, enable=1, at terminal, oneshot=1:
  - count unchanged, state to DONE, tc=1 for one period.
- DONE:
  - count frozen, tc=0; enable ignored.
  - Leaves only via load (to IDLE) or reset.
- limit=0: count stays 0.
  - Continuous mode: every enabled edge is a wrap, so tc stays high while enable=1.
  - One-shot mode: first enabled edge enters DONE with one tc pulse.
- Runtime changes: up_down, limit and oneshot take effect at the next active edge; no internal shadowing.
- Arithmetic: unsigned WIDTH-bit; no carry beyond WIDTH is ever produced, because wraps are explicit.
- Latency: count and tc change only on active edges (plus async reset); no combinational input-to-output paths.

Optional Feature:
- Macro: COUNTER_OVF_STICKY_EN.
- Defined:
  - Adds input ovf_clear (1) and output ovf_sticky (1).
  - ovf_sticky sets on any edge that produces a tc pulse.
  - ovf_sticky clears on an edge with ovf_clear=1; set wins if both occur on the same edge.
  - Async reset sets it to 0.
- Undefined: both ports and the register are absent; all other behaviour is identical.

Decomposition:
- Package counter_pkg:
  - state typedef: ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10.
  - constants DIR_UP=1'b1, DIR_DOWN=1'b0.
- Sub-module counter_next_calc:
  - Combinational.
  - Inputs: count, limit, up_down.
  - Outputs: next_count and at_terminal.
  - Instanced once; the top holds the FSM, registers and edge selection (generate on NEGEDGE).

Test Plan:
- Reset/edge:
  - WIDTH=16, NEGEDGE=1, RESET_VAL=0: pulse reset between edges; count=0 immediately.
  - Then enable=1, up: count=1,2,3 changing only on falling edges of clock0.
- Continuous up wrap:
  - limit=5, up, enable=1 from 0: sequence 0,1,2,3,4,5,0.
  - tc high only in the period after the 5→0 edge; busy=1 throughout.
- Down one-shot:
  - load_value=3, load, then up_down=0, oneshot=1, enable=1: count 3,2,1,0 then held at 0.
  - state DONE, one tc pulse, busy=0; further enables leave count=0.
  - A following load of 4 gives count=4, IDLE.
- Load clamp and priority:
  - limit=10, load=1 with load_value=20 and enable=1 on the same edge: count=10, state IDLE, no step taken.
- Limit reduced mid-run:
  - count=8, up, limit changed to 5: next enabled edge gives count=0 with a tc pulse.
- Sticky (macro defined):
  - Two wraps set ovf_sticky=1.
  - ovf_clear asserted on the same edge as a wrap keeps it 1.
  - ovf_clear asserted alone clears it to 0.
